// File: rtl/ifetch_unit.sv
// Instruction fetch front end: one outstanding imem request at a time,
// with responses queued toward decode along with their PCs.
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_write,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    logic [31:0]   req_pc;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic accept;
    logic push;
    logic pop;
    logic has_room;

    assign has_room = (count < CW'(DEPTH));

    assign imem_req  = reset & (state == IDLE) & ~redirect & has_room;
    assign imem_addr = reset ? pc : 32'd0;
    assign accept    = imem_req & imem_gnt;
    assign pc_write  = reset & (accept | redirect);

    assign id_valid  = reset & (count != '0);
    assign id_instr  = reset ? instr_q[rd_ptr] : 32'd0;
    assign id_pc     = reset ? pc_q[rd_ptr] : 32'd0;

    // Redirect wins over push and pop; its flush happens at the same edge.
    assign push = (state == WAIT) & imem_rvalid & ~redirect;
    assign pop  = id_valid & id_ready & ~redirect;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            req_pc <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= WAIT;
                        req_pc <= pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid)
                        state <= IDLE;
                    else if (redirect)
                        state <= DROP;
                end
                DROP: begin
                    if (imem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr]    <= req_pc;
            end

            if (redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push)
            assert (count < CW'(DEPTH));
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, fetch, back-pressure,
// redirect in WAIT/DROP and reset mid-operation.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_write;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    logic [31:0] tgt;
    int          checks = 0;
    int          errors = 0;

    ifetch_unit #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_write    (pc_write),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Models the PC register: load target on redirect, else pc+4.
    task automatic cyc();
        logic pw;
        logic rd;
        pw = pc_write;
        rd = redirect;
        @(posedge clk);
        #1;
        if (pw === 1'b1)
            pc = rd ? tgt : pc + 32'd4;
    endtask

    initial begin
        reset       = 1'b0;
        pc          = 32'h0040_0000;
        redirect    = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        tgt         = '0;

        repeat (3) cyc();
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pw", 32'(pc_write), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_idpc", id_pc, 32'd0);

        reset = 1'b1;
        #1;
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h0040_0000);
        chk("acc_pw", 32'(pc_write), 32'd1);

        // Zero-wait fetch with decode ready
        id_ready = 1'b1;
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2008_0001;
        #1;
        chk("wait_req", 32'(imem_req), 32'd0);
        chk("wait_pw", 32'(pc_write), 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk("zw_valid", 32'(id_valid), 32'd1);
        chk("zw_pc", id_pc, 32'h0040_0000);
        chk("zw_instr", id_instr, 32'h2008_0001);
        chk("zw_addr", imem_addr, 32'h0040_0004);
        imem_gnt = 1'b0;
        #1;
        chk("nogn_req", 32'(imem_req), 32'd1);
        chk("nogn_pw", 32'(pc_write), 32'd0);
        cyc();
        chk("pop_valid", 32'(id_valid), 32'd0);

        // Redirect in IDLE back to 0x400000
        redirect = 1'b1;
        tgt      = 32'h0040_0000;
        id_ready = 1'b0;
        imem_gnt = 1'b1;
        #1;
        chk("ridl_req", 32'(imem_req), 32'd0);
        chk("ridl_pw", 32'(pc_write), 32'd1);
        cyc();
        redirect = 1'b0;
        #1;
        chk("ridl_addr", imem_addr, 32'h0040_0000);

        // Fill the queue with decode stalled
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2008_0001;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk("fill2_addr", imem_addr, 32'h0040_0004);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_pw", 32'(pc_write), 32'd0);
        chk("full_pc", id_pc, 32'h0040_0000);
        chk("full_instr", id_instr, 32'h2008_0001);
        cyc();
        chk("hold_pc", id_pc, 32'h0040_0000);
        chk("hold_req", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        #1;
        chk("pop1_req", 32'(imem_req), 32'd0);
        cyc();
        chk("pop2_pc", id_pc, 32'h0040_0004);
        chk("pop2_instr", id_instr, 32'h0000_0013);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h0040_0008);

        // Redirect while WAIT, late response must be dropped
        id_ready = 1'b0;
        cyc();
        redirect = 1'b1;
        tgt      = 32'h8000_0180;
        #1;
        chk("rw_pw", 32'(pc_write), 32'd1);
        chk("rw_req", 32'(imem_req), 32'd0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("rw_flush", 32'(id_valid), 32'd0);
        chk("drop_req", 32'(imem_req), 32'd0);
        cyc();
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("drop_req2", 32'(imem_req), 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk("late_valid", 32'(id_valid), 32'd0);
        chk("new_req", 32'(imem_req), 32'd1);
        chk("new_addr", imem_addr, 32'h8000_0180);

        // Redirect coinciding with rvalid
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        redirect    = 1'b1;
        tgt         = 32'h8000_0200;
        #1;
        chk("rv_pw", 32'(pc_write), 32'd1);
        cyc();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("rv_valid", 32'(id_valid), 32'd0);
        chk("rv_req", 32'(imem_req), 32'd1);
        chk("rv_addr", imem_addr, 32'h8000_0200);

        // Reset while in DROP, then stale rvalid
        cyc();
        redirect = 1'b1;
        tgt      = 32'h8000_0300;
        cyc();
        redirect = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rd_req", 32'(imem_req), 32'd0);
        chk("rd_pw", 32'(pc_write), 32'd0);
        chk("rd_addr", imem_addr, 32'd0);
        cyc();
        chk("rd_valid", 32'(id_valid), 32'd0);
        chk("rd_idpc", id_pc, 32'd0);
        chk("rd_instr", id_instr, 32'd0);
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0BAD;
        #1;
        chk("stale_req", 32'(imem_req), 32'd1);
        chk("stale_pw", 32'(pc_write), 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk("stale_valid", 32'(id_valid), 32'd0);
        chk("stale_req2", 32'(imem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
